jpeg_fb_writer: RTL

JPEG_FB_WRITER -- requirements
Module: jpeg_fb_writer

---
 rtl/jpeg_fb_writer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/jpeg_fb_writer.sv
// JPEG decoder framebuffer writer: converts pixels to RGB565 halfword writes
// through a one-entry pixel stage and a small write FIFO, and tracks frame completion.
module jpeg_fb_writer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] cfg_base_i,
    input  logic [15:0] cfg_stride_i,
    input  logic        pixel_valid_i,
    output logic        pixel_accept_o,
    input  logic [15:0] pixel_width_i,
    input  logic [15:0] pixel_height_i,
    input  logic [15:0] pixel_x_i,
    input  logic [15:0] pixel_y_i,
    input  logic [7:0]  pixel_r_i,
    input  logic [7:0]  pixel_g_i,
    input  logic [7:0]  pixel_b_i,
    output logic        mem_req_o,
    input  logic        mem_accept_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_strb_o,
    output logic        frame_done_o,
    output logic        idle_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_req_t;

    // Registered state
    logic          ready_q;
    logic          s1_valid_q, s1_valid_d;
    logic [15:0]   s1_x_q, s1_x_d;
    logic [15:0]   s1_y_q, s1_y_d;
    logic [7:0]    s1_r_q, s1_r_d;
    logic [7:0]    s1_g_q, s1_g_d;
    logic [7:0]    s1_b_q, s1_b_d;
    logic [31:0]   base_q, base_d;
    logic [15:0]   stride_q, stride_d;
    logic [15:0]   width_q, width_d;
    logic [15:0]   height_q, height_d;
    logic [31:0]   frame_cnt_q, frame_cnt_d;
    logic [31:0]   retired_q, retired_d;
    logic          idle_q, idle_d;
    logic          done_q, done_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    wr_req_t       fifo_q [FIFO_DEPTH];

    // Combinational helpers
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty;
    logic          fifo_full;
    logic [31:0]   frame_total;
    logic          frame_received;
    logic          pix_hs;
    logic          s1_clip;
    logic          s1_push;
    logic          s1_drop;
    logic          mem_pop;
    logic [1:0]    retire_inc;
    logic [31:0]   retired_sum;
    logic          frame_end;
    logic [31:0]   s1_addr;
    logic [15:0]   s1_rgb565;
    wr_req_t       s1_req;
    wr_req_t       head;
    logic          unused_color_bits;

    assign fifo_cnt    = wr_ptr_q - rd_ptr_q;
    assign fifo_empty  = (fifo_cnt == '0);
    assign fifo_full   = (fifo_cnt == CW'(FIFO_DEPTH));
    assign frame_total = 32'(width_q) * 32'(height_q);

    // Once every pixel of the frame has been taken, stall until it fully retires
    assign frame_received = (frame_cnt_q != 32'd0) && (frame_cnt_q >= frame_total);

    // S1 is always free unless it holds a pixel that cannot enter a full FIFO
    assign pixel_accept_o = ready_q & ~(s1_valid_q & fifo_full) & ~frame_received;
    assign pix_hs         = pixel_valid_i & pixel_accept_o;

    assign s1_clip   = (s1_x_q >= width_q) | (s1_y_q >= height_q);
    assign s1_push   = s1_valid_q & ~s1_clip & ~fifo_full;
    assign s1_drop   = s1_valid_q & s1_clip;
    assign mem_pop   = ~fifo_empty & mem_accept_i;

    assign retire_inc  = {1'b0, mem_pop} + {1'b0, s1_drop};
    assign retired_sum = retired_q + 32'(retire_inc);
    assign frame_end   = (retire_inc != 2'd0) && (retired_sum >= frame_total);

    assign s1_addr   = (base_q + (32'(s1_y_q) * 32'(stride_q)) + {15'd0, s1_x_q, 1'b0})
                       & 32'hFFFF_FFFE;
    assign s1_rgb565 = {s1_r_q[7:3], s1_g_q[7:2], s1_b_q[7:3]};

    always_comb begin
        s1_req      = '0;
        s1_req.addr = s1_addr;
        s1_req.data = {s1_rgb565, s1_rgb565};
        s1_req.strb = s1_addr[1] ? 4'b1100 : 4'b0011;
    end

    assign unused_color_bits = ^{s1_r_q[2:0], s1_g_q[1:0], s1_b_q[2:0]};

    // Next-state logic
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_x_d      = s1_x_q;
        s1_y_d      = s1_y_q;
        s1_r_d      = s1_r_q;
        s1_g_d      = s1_g_q;
        s1_b_d      = s1_b_q;
        base_d      = base_q;
        stride_d    = stride_q;
        width_d     = width_q;
        height_d    = height_q;
        frame_cnt_d = frame_cnt_q;
        retired_d   = retired_q;
        idle_d      = idle_q;
        done_d      = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        if (s1_push || s1_drop) begin
            s1_valid_d = 1'b0;
        end
        if (pix_hs) begin
            s1_valid_d  = 1'b1;
            s1_x_d      = pixel_x_i;
            s1_y_d      = pixel_y_i;
            s1_r_d      = pixel_r_i;
            s1_g_d      = pixel_g_i;
            s1_b_d      = pixel_b_i;
            frame_cnt_d = frame_cnt_q + 32'd1;
            if (frame_cnt_q == 32'd0) begin
                base_d   = cfg_base_i;
                stride_d = cfg_stride_i;
                width_d  = pixel_width_i;
                height_d = pixel_height_i;
                idle_d   = 1'b0;
            end
        end

        if (s1_push) begin
            wr_ptr_d = wr_ptr_q + CW'(1);
        end
        if (mem_pop) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
        end

        retired_d = retired_sum;
        if (frame_end) begin
            retired_d   = 32'd0;
            frame_cnt_d = 32'd0;
            done_d      = 1'b1;
            idle_d      = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= 16'd0;
            s1_y_q      <= 16'd0;
            s1_r_q      <= 8'd0;
            s1_g_q      <= 8'd0;
            s1_b_q      <= 8'd0;
            base_q      <= 32'd0;
            stride_q    <= 16'd0;
            width_q     <= 16'd0;
            height_q    <= 16'd0;
            frame_cnt_q <= 32'd0;
            retired_q   <= 32'd0;
            idle_q      <= 1'b1;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            ready_q     <= 1'b1;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_r_q      <= s1_r_d;
            s1_g_q      <= s1_g_d;
            s1_b_q      <= s1_b_d;
            base_q      <= base_d;
            stride_q    <= stride_d;
            width_q     <= width_d;
            height_q    <= height_d;
            frame_cnt_q <= frame_cnt_d;
            retired_q   <= retired_d;
            idle_q      <= idle_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset: outputs are gated by occupancy
    always_ff @(posedge clk_i) begin
        if (s1_push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= s1_req;
        end
    end

    assign head         = fifo_q[rd_ptr_q[AW-1:0]];
    assign mem_req_o    = ~fifo_empty;
    assign mem_addr_o   = mem_req_o ? head.addr : 32'd0;
    assign mem_data_o   = mem_req_o ? head.data : 32'd0;
    assign mem_strb_o   = mem_req_o ? head.strb : 4'd0;
    assign frame_done_o = done_q;
    assign idle_o       = idle_q;

endmodule
